// File: rtl/ex_stage_pkg.sv
// Shared types and default widths for the execute stage and its multiplier.
`ifndef EX_STAGE_DEFS
`define EX_STAGE_DEFS
`define EX_XLEN        32
`define EX_PRF_IDX_W   6
`define EX_BMASK_W     4
`define EX_MULT_STAGES 4
`endif

package ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_func_t;

    typedef enum logic [1:0] {
        MULT_MUL    = 2'd0,
        MULT_MULH   = 2'd1,
        MULT_MULHSU = 2'd2,
        MULT_MULHU  = 2'd3
    } mult_func_t;

    typedef logic [`EX_BMASK_W-1:0] branch_mask_t;

    typedef struct packed {
        logic                     valid;
        logic [`EX_PRF_IDX_W-1:0] tag;
        branch_mask_t             bmask;
        logic [`EX_XLEN-1:0]      data;
    } ex_entry_t;

endpackage

// File: rtl/ex_stage_mult_pipe.sv
// Pipelined shift-add multiplier; each stage folds in XLEN/STAGES multiplier bits.
// Holds per-stage valid/tag/bmask and applies squash/resolve to every stage and the inbound op.
module mult_pipe
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = `EX_XLEN,
    parameter int PRF_IDX_W = `EX_PRF_IDX_W,
    parameter int BMASK_W   = `EX_BMASK_W,
    parameter int STAGES    = `EX_MULT_STAGES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 in_valid,
    input  logic [1:0]           in_func,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [PRF_IDX_W-1:0] in_tag,
    input  logic [BMASK_W-1:0]   in_bmask,
    input  logic [BMASK_W-1:0]   smask,
    input  logic [BMASK_W-1:0]   rmask,
    output logic                 out_valid,
    output logic [PRF_IDX_W-1:0] out_tag,
    output logic [XLEN-1:0]      out_data
);
    localparam int CH = XLEN / STAGES;
    localparam int W2 = 2 * XLEN;

    function automatic logic [W2-1:0] pp(input logic [W2-1:0] mc, input logic [CH-1:0] bits,
                                         input int base);
        logic [W2-1:0] s;
        s = '0;
        for (int j = 0; j < CH; j++)
            if (bits[j]) s = s + (mc << (base + j));
        return s;
    endfunction

    logic [STAGES-1:0]    vld_pipe, hi_q;
    logic [BMASK_W-1:0]   bm_q  [STAGES];
    logic [PRF_IDX_W-1:0] tag_q [STAGES];
    logic [W2-1:0]        mc_q  [STAGES];
    logic [XLEN-1:0]      mp_q  [STAGES];
    logic [W2-1:0]        acc_q [STAGES];

    logic [STAGES-1:0]    src_v, src_hi;
    logic [BMASK_W-1:0]   src_bm  [STAGES];
    logic [PRF_IDX_W-1:0] src_tag [STAGES];
    logic [W2-1:0]        src_mc  [STAGES];
    logic [XLEN-1:0]      src_mp  [STAGES];
    logic [W2-1:0]        src_acc [STAGES];
    logic [W2-1:0]        acc_nxt [STAGES];

    mult_func_t    fn;
    logic          a_sgn, b_sgn;
    logic [W2-1:0] mc_in, acc_in;

    // A negative signed multiplier is handled by seeding the accumulator with -(mcand << XLEN).
    always_comb begin
        fn     = mult_func_t'(in_func);
        a_sgn  = (fn != MULT_MULHU);
        b_sgn  = (fn == MULT_MUL) || (fn == MULT_MULH);
        mc_in  = a_sgn ? {{XLEN{in_rs1[XLEN-1]}}, in_rs1} : {{XLEN{1'b0}}, in_rs1};
        acc_in = (b_sgn && in_rs2[XLEN-1]) ? -{mc_in[XLEN-1:0], {XLEN{1'b0}}} : '0;
    end

    always_comb begin
        src_v[0]   = in_valid;
        src_hi[0]  = (fn != MULT_MUL);
        src_bm[0]  = in_bmask;
        src_tag[0] = in_tag;
        src_mc[0]  = mc_in;
        src_mp[0]  = in_rs2;
        src_acc[0] = acc_in;
        for (int s = 1; s < STAGES; s++) begin
            src_v[s]   = vld_pipe[s-1];
            src_hi[s]  = hi_q[s-1];
            src_bm[s]  = bm_q[s-1];
            src_tag[s] = tag_q[s-1];
            src_mc[s]  = mc_q[s-1];
            src_mp[s]  = mp_q[s-1];
            src_acc[s] = acc_q[s-1];
        end
        for (int s = 0; s < STAGES; s++)
            acc_nxt[s] = src_acc[s] + pp(src_mc[s], src_mp[s][s*CH +: CH], s * CH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            hi_q     <= '0;
            for (int s = 0; s < STAGES; s++) begin
                bm_q[s]  <= '0;
                tag_q[s] <= '0;
                mc_q[s]  <= '0;
                mp_q[s]  <= '0;
                acc_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (!stall) begin
                    vld_pipe[s] <= src_v[s] && !(|(src_bm[s] & smask));
                    hi_q[s]     <= src_hi[s];
                    bm_q[s]     <= src_bm[s] & ~rmask;
                    tag_q[s]    <= src_tag[s];
                    mc_q[s]     <= src_mc[s];
                    mp_q[s]     <= src_mp[s];
                    acc_q[s]    <= acc_nxt[s];
                end else begin
                    vld_pipe[s] <= vld_pipe[s] && !(|(bm_q[s] & smask));
                    bm_q[s]     <= bm_q[s] & ~rmask;
                end
            end
        end
    end

    assign out_valid = vld_pipe[STAGES-1] && !(|(bm_q[STAGES-1] & smask));
    assign out_tag   = tag_q[STAGES-1];
    assign out_data  = hi_q[STAGES-1] ? acc_q[STAGES-1][W2-1:XLEN] : acc_q[STAGES-1][XLEN-1:0];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU with a one-entry result register plus a pipelined
// multiplier, both feeding the CDB request; the multiplier (older) wins conflicts.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN        = `EX_XLEN,
    parameter int PRF_IDX_W   = `EX_PRF_IDX_W,
    parameter int BMASK_W     = `EX_BMASK_W,
    parameter int MULT_STAGES = `EX_MULT_STAGES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 is_valid,
    input  logic                 is_mult,
    input  logic [3:0]           is_func,
    input  logic [XLEN-1:0]      is_rs1,
    input  logic [XLEN-1:0]      is_rs2,
    input  logic [XLEN-1:0]      is_imm,
    input  logic                 is_use_imm,
    input  logic [PRF_IDX_W-1:0] is_tag,
    input  logic [BMASK_W-1:0]   is_bmask,
    output logic                 alu_ready,
    output logic                 mult_ready,
    input  logic                 squash_valid,
    input  logic                 resolve_valid,
    input  logic [BMASK_W-1:0]   squash_bit,
    input  logic [BMASK_W-1:0]   resolve_bit,
    output logic                 cdb_req,
    output logic [PRF_IDX_W-1:0] cdb_tag,
    output logic [XLEN-1:0]      cdb_data,
    input  logic                 cdb_gnt
);
    logic [BMASK_W-1:0] smask, rmask;
    assign smask = squash_valid  ? squash_bit  : '0;
    assign rmask = resolve_valid ? resolve_bit : '0;

    logic [XLEN-1:0] op_b, alu_res;
    always_comb begin
        op_b    = is_use_imm ? is_imm : is_rs2;
        alu_res = '0;
        case (alu_func_t'(is_func))
            ALU_ADD:  alu_res = is_rs1 + op_b;
            ALU_SUB:  alu_res = is_rs1 - op_b;
            ALU_AND:  alu_res = is_rs1 & op_b;
            ALU_OR:   alu_res = is_rs1 | op_b;
            ALU_XOR:  alu_res = is_rs1 ^ op_b;
            ALU_SLL:  alu_res = is_rs1 << op_b[4:0];
            ALU_SRL:  alu_res = is_rs1 >> op_b[4:0];
            ALU_SRA:  alu_res = $signed(is_rs1) >>> op_b[4:0];
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(is_rs1) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (is_rs1 < op_b)};
            default:  alu_res = '0;
        endcase
    end

    logic                 alu_v;
    logic [PRF_IDX_W-1:0] alu_tag;
    logic [BMASK_W-1:0]   alu_bm;
    logic [XLEN-1:0]      alu_data;

    logic                 m_v;
    logic [PRF_IDX_W-1:0] m_tag;
    logic [XLEN-1:0]      m_data;

    logic alu_live, pop_alu, mult_stall, alu_acc, inb_squash, mult_in_v;

    // Squashed entries count as empty this cycle so their slot is reusable at once.
    assign alu_live   = alu_v && !(|(alu_bm & smask));
    assign pop_alu    = cdb_gnt && alu_live && !m_v;
    assign alu_ready  = !alu_live || pop_alu;
    assign mult_stall = m_v && !cdb_gnt;
    assign mult_ready = !mult_stall;
    assign inb_squash = |(is_bmask & smask);
    assign alu_acc    = is_valid && !is_mult && alu_ready && (is_tag != '0) && !inb_squash;
    assign mult_in_v  = is_valid && is_mult && mult_ready && (is_tag != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_v    <= 1'b0;
            alu_tag  <= '0;
            alu_bm   <= '0;
            alu_data <= '0;
        end else if (alu_acc) begin
            alu_v    <= 1'b1;
            alu_tag  <= is_tag;
            alu_bm   <= is_bmask & ~rmask;
            alu_data <= alu_res;
        end else begin
            if (pop_alu || !alu_live) alu_v <= 1'b0;
            alu_bm <= alu_bm & ~rmask;
        end
    end

    mult_pipe #(
        .XLEN(XLEN), .PRF_IDX_W(PRF_IDX_W), .BMASK_W(BMASK_W), .STAGES(MULT_STAGES)
    ) u_mult (
        .clock    (clock),
        .reset    (reset),
        .stall    (mult_stall),
        .in_valid (mult_in_v),
        .in_func  (is_func[1:0]),
        .in_rs1   (is_rs1),
        .in_rs2   (op_b),
        .in_tag   (is_tag),
        .in_bmask (is_bmask),
        .smask    (smask),
        .rmask    (rmask),
        .out_valid(m_v),
        .out_tag  (m_tag),
        .out_data (m_data)
    );

    assign cdb_req  = m_v || alu_live;
    assign cdb_tag  = m_v ? m_tag  : (alu_live ? alu_tag  : '0);
    assign cdb_data = m_v ? m_data : (alu_live ? alu_data : '0);

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected results are queued per class at accept and
// checked at each CDB grant; directed checks cover latency, priority, stall, squash, reset.
`timescale 1ns/1ps
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        is_valid = 1'b0, is_mult = 1'b0, is_use_imm = 1'b0;
    logic [3:0]  is_func = '0;
    logic [31:0] is_rs1 = '0, is_rs2 = '0, is_imm = '0;
    logic [5:0]  is_tag = '0;
    logic [3:0]  is_bmask = '0;
    logic        alu_ready, mult_ready;
    logic        squash_valid = 1'b0, resolve_valid = 1'b0;
    logic [3:0]  squash_bit = '0, resolve_bit = '0;
    logic        cdb_req;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_gnt = 1'b0;

    always #5 clock = ~clock;

    ex_stage #(.XLEN(32), .PRF_IDX_W(6), .BMASK_W(4), .MULT_STAGES(4)) dut (
        .clock(clock), .reset(reset),
        .is_valid(is_valid), .is_mult(is_mult), .is_func(is_func),
        .is_rs1(is_rs1), .is_rs2(is_rs2), .is_imm(is_imm), .is_use_imm(is_use_imm),
        .is_tag(is_tag), .is_bmask(is_bmask),
        .alu_ready(alu_ready), .mult_ready(mult_ready),
        .squash_valid(squash_valid), .resolve_valid(resolve_valid),
        .squash_bit(squash_bit), .resolve_bit(resolve_bit),
        .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_gnt(cdb_gnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $signed(a) >>> b[4:0];
            4'd8: return {31'b0, ($signed(a) < $signed(b))};
            4'd9: return {31'b0, (a < b)};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mult_model(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f != 2'd3) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f <= 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // ALU tags use bit 5 = 0, mult tags bit 5 = 1; each class completes in order.
    ex_entry_t aq[$];
    ex_entry_t mq[$];
    ex_entry_t tq[$];
    ex_entry_t e_pop, e_new;
    logic [31:0] b_eff;

    always @(negedge clock) begin
        if (reset) begin
            if (cdb_req && cdb_gnt) begin
                if (cdb_tag[5]) begin
                    chk("sb_mult_pending", mq.size() != 0, 1);
                    if (mq.size() != 0) begin
                        e_pop = mq.pop_front();
                        chk("cdb_tag_mult", cdb_tag, e_pop.tag);
                        chk("cdb_data_mult", cdb_data, e_pop.data);
                    end
                end else begin
                    chk("sb_alu_pending", aq.size() != 0, 1);
                    if (aq.size() != 0) begin
                        e_pop = aq.pop_front();
                        chk("cdb_tag_alu", cdb_tag, e_pop.tag);
                        chk("cdb_data_alu", cdb_data, e_pop.data);
                    end
                end
            end
            if (squash_valid) begin
                tq = {};
                foreach (aq[i]) if (!(|(aq[i].bmask & squash_bit))) tq.push_back(aq[i]);
                aq = tq;
                tq = {};
                foreach (mq[i]) if (!(|(mq[i].bmask & squash_bit))) tq.push_back(mq[i]);
                mq = tq;
            end
            if (resolve_valid) begin
                foreach (aq[i]) aq[i].bmask = aq[i].bmask & ~resolve_bit;
                foreach (mq[i]) mq[i].bmask = mq[i].bmask & ~resolve_bit;
            end
            if (is_valid && is_tag != 0 && (is_mult ? mult_ready : alu_ready) &&
                !(squash_valid && |(is_bmask & squash_bit))) begin
                b_eff       = is_use_imm ? is_imm : is_rs2;
                e_new.valid = 1'b1;
                e_new.tag   = is_tag;
                e_new.bmask = is_bmask & ~(resolve_valid ? resolve_bit : 4'b0);
                e_new.data  = is_mult ? mult_model(is_func[1:0], is_rs1, b_eff)
                                      : alu_model(is_func, is_rs1, b_eff);
                if (is_mult) mq.push_back(e_new);
                else         aq.push_back(e_new);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic m, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] t, input logic [3:0] bm);
        is_valid = 1'b1; is_mult = m; is_func = f; is_rs1 = a; is_rs2 = b;
        is_imm = '0; is_use_imm = 1'b0; is_tag = t; is_bmask = bm;
    endtask

    task automatic idle();
        is_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((aq.size() != 0 || mq.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_left", aq.size() + mq.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clock);
        chk("rst_req", cdb_req, 0);
        chk("rst_tag", cdb_tag, 0);
        chk("rst_data", cdb_data, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mult_ready", mult_ready, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        cdb_gnt = 1'b1;

        // ADD: one-cycle latency, gone the cycle after the grant
        issue(0, 4'd0, 32'd5, 32'd7, 6'd3, 4'd0);
        @(negedge clock); chk("add_alu_ready", alu_ready, 1);
        cyc(); idle();
        @(negedge clock);
        chk("add_req", cdb_req, 1);
        chk("add_tag", cdb_tag, 3);
        chk("add_data", cdb_data, 12);
        cyc();
        @(negedge clock); chk("add_req_after", cdb_req, 0);

        // MULH / MULHU latency and signedness
        cyc(); issue(1, 4'd1, 32'h8000_0000, 32'd2, 6'd33, 4'd0);
        @(negedge clock); chk("mulh_mult_ready", mult_ready, 1);
        cyc(); idle();
        cyc(); cyc();
        @(negedge clock); chk("mulh_not_early", cdb_req, 0);
        cyc();
        @(negedge clock);
        chk("mulh_req", cdb_req, 1);
        chk("mulh_data", cdb_data, 32'hFFFF_FFFF);
        cyc(); issue(1, 4'd3, 32'h8000_0000, 32'd2, 6'd34, 4'd0);
        cyc(); idle();
        cyc(); cyc(); cyc();
        @(negedge clock); chk("mulhu_data", cdb_data, 1);

        // ALU and mult complete together: mult first, ALU waits
        cyc(); issue(1, 4'd0, 32'd6, 32'd7, 6'd35, 4'd0);
        cyc(); idle();
        cyc(); cyc();
        issue(0, 4'd0, 32'd100, 32'd23, 6'd4, 4'd0);
        cyc(); idle();
        @(negedge clock);
        chk("conf_tag_mult", cdb_tag, 35);
        chk("conf_data_mult", cdb_data, 42);
        chk("conf_alu_ready", alu_ready, 0);
        cyc();
        @(negedge clock);
        chk("conf_tag_alu", cdb_tag, 4);
        chk("conf_data_alu", cdb_data, 123);
        drain(5);

        // grant held low: pipeline fills and stalls, ALU entry held, nothing lost
        cyc(); cdb_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1, 4'd0, 32'(i + 2), 32'(i + 10), 6'(36 + i), 4'd0);
            cyc();
        end
        issue(0, 4'd1, 32'd50, 32'd8, 6'd5, 4'd0);
        @(negedge clock); chk("stall_mready_full", mult_ready, 0);
        cyc(); idle();
        @(negedge clock);
        chk("stall_mready", mult_ready, 0);
        chk("stall_aready", alu_ready, 0);
        chk("stall_req", cdb_req, 1);
        chk("stall_tag", cdb_tag, 36);
        repeat (5) cyc();
        @(negedge clock);
        chk("stall_tag_hold", cdb_tag, 36);
        chk("stall_data_hold", cdb_data, 20);
        cyc(); cdb_gnt = 1'b1;
        drain(20);

        // squash in-flight MULs on bit 0; resolved MUL on bit 1 survives a later squash of bit 1
        cyc();
        issue(1, 4'd0, 32'd3, 32'd3, 6'd40, 4'b0001); cyc();
        issue(1, 4'd0, 32'd4, 32'd4, 6'd41, 4'b0001); cyc();
        issue(1, 4'd0, 32'd5, 32'd5, 6'd42, 4'b0001); cyc();
        issue(1, 4'd0, 32'd9, 32'd9, 6'd43, 4'b0010);
        squash_valid = 1'b1; squash_bit = 4'b0001;
        resolve_valid = 1'b1; resolve_bit = 4'b0010;
        @(negedge clock);
        chk("sq_req", cdb_req, 0);
        chk("sq_mready", mult_ready, 1);
        cyc(); idle(); squash_valid = 1'b0; resolve_valid = 1'b0;
        cyc();
        squash_valid = 1'b1; squash_bit = 4'b0010;
        cyc(); squash_valid = 1'b0;
        drain(10);

        // squashed ALU entry is dropped from the request the same cycle
        cdb_gnt = 1'b0;
        issue(0, 4'd0, 32'd1, 32'd1, 6'd6, 4'b0100);
        cyc(); idle();
        @(negedge clock);
        chk("alu_sq_held", cdb_req, 1);
        chk("alu_sq_aready_busy", alu_ready, 0);
        cyc(); squash_valid = 1'b1; squash_bit = 4'b0100;
        @(negedge clock);
        chk("alu_sq_req", cdb_req, 0);
        chk("alu_sq_aready", alu_ready, 1);
        cyc(); squash_valid = 1'b0; cdb_gnt = 1'b1;
        @(negedge clock); chk("alu_sq_gone", cdb_req, 0);

        // tag 0 is accepted but never broadcast
        cyc(); issue(0, 4'd0, 32'd1, 32'd2, 6'd0, 4'd0);
        cyc(); idle();
        @(negedge clock); chk("tag0_req", cdb_req, 0);

        // mixed sweep over all ALU and mult functions
        for (int f = 0; f < 10; f++) begin
            cyc();
            issue(0, 4'(f), $urandom, $urandom, 6'(f + 1), 4'd0);
            is_use_imm = f[0];
            is_imm = $urandom;
        end
        for (int f = 0; f < 8; f++) begin
            cyc();
            issue(1, 4'(f % 4), $urandom, $urandom, 6'(48 + f), 4'd0);
        end
        cyc(); idle();
        drain(20);

        // reset mid-pipeline drops everything immediately
        cyc(); issue(1, 4'd0, 32'd7, 32'd7, 6'd50, 4'd0);
        cyc(); issue(0, 4'd0, 32'd1, 32'd1, 6'd7, 4'd0);
        cyc(); idle(); cdb_gnt = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("mrst_req", cdb_req, 0);
        chk("mrst_tag", cdb_tag, 0);
        chk("mrst_aready", alu_ready, 1);
        chk("mrst_mready", mult_ready, 1);
        aq.delete();
        mq.delete();
        @(posedge clock); #1;
        reset = 1'b1; cdb_gnt = 1'b1;
        repeat (6) begin
            @(negedge clock);
            chk("post_rst_req", cdb_req, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
